// File: rtl/aes_inv_cipher_pkg.sv
// aes_inv_cipher_pkg: FSM encoding, Rcon table and AES round/S-box functions shared by the inverse cipher
package aes_inv_cipher_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [79:0] RCON_TAB = 80'h01020408102040801b36;
  function automatic logic [7:0] rcon(input logic [3:0] i);
    return RCON_TAB[8*(10-int'(i)) +: 8];
  endfunction
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = b[i] ? p ^ x : p;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
  // GF(2^8) inverse as x^254; zero maps to zero as AES requires
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r, s;
    r = 8'h01;
    s = a;
    for (int i = 0; i < 7; i++) begin
      s = gmul(s, s);
      r = gmul(r, s);
    end
    return r;
  endfunction
  function automatic logic [7:0] sbox_byte(input logic [7:0] a);
    logic [7:0] b;
    b = ginv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction
  function automatic logic [7:0] inv_sbox_byte(input logic [7:0] b);
    return ginv({b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05);
  endfunction
  // byte i sits at [127-8i] with row i%4, column i/4; row r rotates right by r
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
    return o;
  endfunction
  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [7:0] a [4];
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) a[r] = s[127-8*(4*c+r) -: 8];
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = gmul(a[r], 8'h0e) ^ gmul(a[(r+1)%4], 8'h0b) ^
                                gmul(a[(r+2)%4], 8'h0d) ^ gmul(a[(r+3)%4], 8'h09);
    end
    return o;
  endfunction
  function automatic logic [127:0] add_round_key(input logic [127:0] s, input logic [127:0] k);
    return s ^ k;
  endfunction
endpackage

// File: rtl/aes_inv_sbox.sv
// aes_inv_sbox: word-wide inverse AES S-box (InvSubBytes on one column)
module aes_inv_sbox
  import aes_inv_cipher_pkg::*;
(
  input  logic [31:0] din,
  output logic [31:0] dout
);
  // inverse-substitute each byte of the word
  always_comb begin
    dout = '0;
    for (int i = 0; i < 4; i++) dout[8*i +: 8] = inv_sbox_byte(din[8*i +: 8]);
  end
endmodule

// File: rtl/aes_sbox.sv
// aes_sbox: word-wide forward AES S-box (SubWord)
module aes_sbox
  import aes_inv_cipher_pkg::*;
(
  input  logic [31:0] din,
  output logic [31:0] dout
);
  // substitute each byte of the word
  always_comb begin
    dout = '0;
    for (int i = 0; i < 4; i++) dout[8*i +: 8] = sbox_byte(din[8*i +: 8]);
  end
endmodule

// File: rtl/aes_inv_cipher.sv
// aes_inv_cipher: iterative AES-128 decryption, one round per cycle; AES_INV_KEY_OUT_EN adds o_rnd0_key
module aes_inv_cipher
  import aes_inv_cipher_pkg::*;
#(
  parameter int RND_SIZE = 128,
  parameter int WRD_SIZE = 32,
  parameter int NUM_BLK  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [RND_SIZE-1:0] i_cypher,
  input  logic [RND_SIZE-1:0] i_lst_key,
  output logic                o_valid,
  input  logic                i_out_ready,
  output logic [RND_SIZE-1:0] o_plain
`ifdef AES_INV_KEY_OUT_EN
  ,
  output logic [RND_SIZE-1:0] o_rnd0_key
`endif
);
  state_t st, st_nxt;
  logic [RND_SIZE-1:0] s_reg, k_reg, k_nxt, sr, isb, ark, rnd;
  logic [31:0] w0, w1, w2, w3, sw;
  logic [3:0] cnt;
  assign w3 = k_reg[31:0] ^ k_reg[63:32];
  assign w2 = k_reg[63:32] ^ k_reg[95:64];
  assign w1 = k_reg[95:64] ^ k_reg[127:96];
  aes_sbox u_key_sbox (.din({w3[23:0], w3[31:24]}), .dout(sw));
  assign w0 = k_reg[127:96] ^ sw ^ {rcon(cnt + 4'd1), 24'h0};
  assign k_nxt = {w0, w1, w2, w3};
  assign sr = inv_shift_rows(s_reg);
  for (genvar g = 0; g < NUM_BLK; g++) begin : g_isb
    aes_inv_sbox u_inv_sbox (
      .din (sr[RND_SIZE-1-WRD_SIZE*g -: WRD_SIZE]),
      .dout(isb[RND_SIZE-1-WRD_SIZE*g -: WRD_SIZE])
    );
  end
  assign ark = add_round_key(isb, k_nxt);
  assign rnd = cnt != 4'd0 ? inv_mix_columns(ark) : ark;
  // FSM state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) st <= IDLE;
    else st <= st_nxt;
  // next state and handshake outputs
  always_comb begin
    st_nxt = st == IDLE ? (i_valid ? RUN : IDLE) :
             st == RUN  ? (cnt == 4'd0 ? DONE : RUN) :
                          (i_out_ready ? IDLE : DONE);
    o_ready = st == IDLE;
    o_valid = st == DONE;
  end
  // load on accept, one inverse round per RUN cycle, capture plaintext on the last round
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s_reg   <= '0;
      k_reg   <= '0;
      cnt     <= '0;
      o_plain <= '0;
    end else if (st == IDLE && i_valid) begin
      s_reg <= i_cypher ^ i_lst_key;
      k_reg <= i_lst_key;
      cnt   <= 4'd9;
    end else if (st == RUN) begin
      s_reg   <= rnd;
      k_reg   <= k_nxt;
      cnt     <= cnt == 4'd0 ? 4'd0 : cnt - 4'd1;
      o_plain <= cnt == 4'd0 ? rnd : o_plain;
    end
`ifdef AES_INV_KEY_OUT_EN
  // the key derived in the final round is the original cipher key
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) o_rnd0_key <= '0;
    else if (st == RUN && cnt == 4'd0) o_rnd0_key <= k_nxt;
`endif
endmodule

// File: tb/tb_aes_inv_cipher.sv
// tb_aes_inv_cipher: directed vectors against a table-driven AES decryption model; AES_INV_KEY_OUT_EN checks o_rnd0_key
module tb_aes_inv_cipher;
  localparam logic [127:0] C1_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_K  = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] C1_PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_K0 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] Z_CT  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [127:0] Z_K   = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
  localparam logic [127:0] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_K   = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;

  logic clk = 0, rst_n = 1, i_valid = 0, i_out_ready = 0;
  logic o_ready, o_valid;
  logic [127:0] i_cypher = '0, i_lst_key = '0, o_plain;
`ifdef AES_INV_KEY_OUT_EN
  logic [127:0] o_rnd0_key;
`endif

  aes_inv_cipher dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_cypher(i_cypher), .i_lst_key(i_lst_key), .o_valid(o_valid),
    .i_out_ready(i_out_ready), .o_plain(o_plain)
`ifdef AES_INV_KEY_OUT_EN
    , .o_rnd0_key(o_rnd0_key)
`endif
  );

  always #5 clk = ~clk;

  int passed = 0, total = 0;
  logic [7:0] sb [256];
  logic [7:0] isb [256];
  logic [7:0] rc [11];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = xt(a);
    end
    return p;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  // run the forward key schedule backwards from the last round key
  function automatic logic [127:0] round_key(input logic [127:0] k10, input int r);
    logic [31:0] w [44];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[40+i] = k10[127-32*i -: 32];
    for (int i = 39; i >= 0; i--) begin
      t = w[i+3];
      if (i % 4 == 0) t = subw({t[23:0], t[31:24]}) ^ {rc[i/4+1], 24'h0};
      w[i] = w[i+4] ^ t;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  function automatic logic [127:0] model_dec(input logic [127:0] ct, input logic [127:0] k10);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] a [4];
    logic [127:0] rk, o;
    for (int i = 0; i < 16; i++) s[i] = ct[127-8*i -: 8] ^ k10[127-8*i -: 8];
    for (int r = 9; r >= 0; r--) begin
      rk = round_key(k10, r);
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++) t[4*c+w] = s[4*((c-w+4)%4)+w];
      for (int i = 0; i < 16; i++) s[i] = isb[t[i]] ^ rk[127-8*i -: 8];
      if (r > 0)
        for (int c = 0; c < 4; c++) begin
          for (int w = 0; w < 4; w++) a[w] = s[4*c+w];
          for (int w = 0; w < 4; w++)
            s[4*c+w] = gm(a[w], 14) ^ gm(a[(w+1)%4], 11) ^ gm(a[(w+2)%4], 13) ^ gm(a[(w+3)%4], 9);
        end
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  // transaction-level expectation: idle, busy for the round count, then holding a result
  int m_phase = 0, m_wait = 0;
  logic [127:0] m_plain = '0, m_pend = '0, m_key = '0, m_pkey = '0;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_phase <= 0;
      m_wait  <= 0;
      m_plain <= '0;
      m_key   <= '0;
    end else if (m_phase == 0) begin
      if (i_valid) begin
        m_pend  <= model_dec(i_cypher, i_lst_key);
        m_pkey  <= round_key(i_lst_key, 0);
        m_wait  <= 10;
        m_phase <= 1;
      end
    end else if (m_phase == 1) begin
      if (m_wait == 1) begin
        m_phase <= 2;
        m_plain <= m_pend;
        m_key   <= m_pkey;
      end else m_wait <= m_wait - 1;
    end else if (i_out_ready) m_phase <= 0;

  always @(negedge clk) begin
    chk("cmp_o_ready", o_ready, m_phase == 0);
    chk("cmp_o_valid", o_valid, m_phase == 2);
    chk("cmp_o_plain", o_plain, m_plain);
`ifdef AES_INV_KEY_OUT_EN
    chk("cmp_o_rnd0_key", o_rnd0_key, m_key);
`endif
  end

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      i_valid = 0;
    end while (!o_valid && n < 30);
  endtask

  task automatic run_vec(input logic [127:0] ct, input logic [127:0] k, input logic [127:0] pt, input string nm);
    int n;
    @(negedge clk);
    i_valid = 1;
    i_cypher = ct;
    i_lst_key = k;
    i_out_ready = 0;
    @(posedge clk);
    wait_valid(n);
    chk({nm, "_latency"}, n, 11);
    chk({nm, "_plain"}, o_plain, pt);
    i_out_ready = 1;
    @(negedge clk);
    i_out_ready = 0;
    chk({nm, "_ready_after"}, {o_ready, o_valid}, 2'b10);
  endtask

  initial begin
    int n;
    for (int x = 0; x < 256; x++) begin
      logic [7:0] v = 0, s;
      for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) v = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = v[i] ^ v[(i+4)%8] ^ v[(i+5)%8] ^ v[(i+6)%8] ^ v[(i+7)%8] ^ ((8'h63 >> i) & 8'h01) != 0;
      sb[x] = s;
    end
    for (int x = 0; x < 256; x++) isb[sb[x]] = 8'(x);
    rc[0] = 8'h00;
    rc[1] = 8'h01;
    for (int j = 2; j < 11; j++) rc[j] = xt(rc[j-1]);
    chk("model_c1_plain", model_dec(C1_CT, C1_K), C1_PT);
    chk("model_c1_key0", round_key(C1_K, 0), C1_K0);
    chk("model_zero_plain", model_dec(Z_CT, Z_K), 128'h0);
    chk("model_b_plain", model_dec(B_CT, B_K), B_PT);
    #1 rst_n = 0;
    repeat (3) @(negedge clk);
    chk("reset_state", {o_ready, o_valid}, 2'b10);
    chk("reset_plain", o_plain, 128'h0);
    #2 rst_n = 1;
    run_vec(C1_CT, C1_K, C1_PT, "c1");
`ifdef AES_INV_KEY_OUT_EN
    chk("c1_key0_held", o_rnd0_key, C1_K0);
`endif
    run_vec(B_CT, B_K, B_PT, "fips_b");
    // back-pressure with noise on the input side
    @(negedge clk);
    i_valid = 1;
    i_cypher = Z_CT;
    i_lst_key = Z_K;
    @(posedge clk);
    wait_valid(n);
    chk("bp_latency", n, 11);
    for (int c = 0; c < 5; c++) begin
      i_valid = c % 2 == 0;
      i_cypher = {$urandom, $urandom, $urandom, $urandom};
      i_lst_key = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      chk("bp_hold_flags", {o_ready, o_valid}, 2'b01);
      chk("bp_hold_plain", o_plain, 128'h0);
    end
    i_valid = 0;
    i_out_ready = 1;
    @(negedge clk);
    i_out_ready = 0;
    chk("bp_release", {o_ready, o_valid}, 2'b10);
    // back-to-back with i_valid held high
    @(negedge clk);
    i_valid = 1;
    i_cypher = Z_CT;
    i_lst_key = Z_K;
    i_out_ready = 1;
    @(posedge clk);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      i_cypher = C1_CT;
      i_lst_key = C1_K;
    end while (!o_valid && n < 30);
    chk("b2b_first_latency", n, 11);
    chk("b2b_first_plain", o_plain, 128'h0);
    @(negedge clk);
    chk("b2b_gap_idle", {o_ready, o_valid}, 2'b10);
    @(negedge clk);
    chk("b2b_second_accepted", o_ready, 1'b0);
    n = 1;
    while (!o_valid && n < 30) begin
      @(negedge clk);
      n++;
      i_valid = 0;
    end
    chk("b2b_second_latency", n, 11);
    chk("b2b_second_plain", o_plain, C1_PT);
    i_valid = 0;
    @(negedge clk);
    i_out_ready = 0;
    // reset in the middle of a block
    @(negedge clk);
    i_valid = 1;
    i_cypher = B_CT;
    i_lst_key = B_K;
    @(posedge clk);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      i_valid = 0;
    end
    #2 rst_n = 0;
    @(negedge clk);
    chk("midrun_reset_flags", {o_ready, o_valid}, 2'b10);
    chk("midrun_reset_plain", o_plain, 128'h0);
    #2 rst_n = 1;
    repeat (2) @(negedge clk);
    chk("after_release_flags", {o_ready, o_valid}, 2'b10);
    chk("after_release_plain", o_plain, 128'h0);
    run_vec(C1_CT, C1_K, C1_PT, "c1_after_reset");
`ifdef AES_INV_KEY_OUT_EN
    chk("c1_after_reset_key0", o_rnd0_key, C1_K0);
`endif
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
endmodule
